adpll_lock_detector: RTL

- Monitors the ADPLL output (fed back as fb_in) against the reference clock (ref_in).
- Sampled on the fast internal clock; measures both periods and the rising-edge phase offset in clk cycles.
- Runs a hysteretic lock state machine that drives a locked status flag and a single-cycle lock-lost pulse.
- Sits beside the ADPLL top level and consumes its reference input and its clk_out.

---
 rtl/adpll_lock_detector.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/adpll_lock_detector.sv
// ADPLL lock detector: measures the reference and feedback periods and their
// rising-edge phase offset in clk cycles, and runs a hysteretic lock FSM that
// drives a locked flag and a single-cycle lock_lost pulse.
module adpll_lock_detector #(
  parameter int CNT_W      = 16,
  parameter int TOL        = 2,
  parameter int PHASE_TOL  = 4,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic             locked,
  output logic             lock_lost,
  output logic [CNT_W-1:0] ref_period,
  output logic [CNT_W-1:0] fb_period,
  output logic [CNT_W-1:0] phase_err
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W:0]   TOL_V       = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]   PHASE_TOL_V = (CNT_W+1)'(PHASE_TOL);
  localparam int               MW          = $clog2(LOCK_CNT + 1);
  localparam int               XW          = $clog2(UNLOCK_CNT + 1);
  localparam logic [MW-1:0]    LOCK_LAST   = MW'(LOCK_CNT - 1);
  localparam logic [XW-1:0]    MISS_LAST   = XW'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic [XW-1:0]    miss_cnt, miss_nxt;
  logic             primed, primed_nxt;
  logic             lost_nxt;
  logic             ref_p0, ref_p1, ref_p2;
  logic             fb_p0, fb_p1, fb_p2;
  logic             ref_edge, fb_edge;
  logic [CNT_W-1:0] ref_cnt, fb_cnt, phase_cnt;
  logic             fb_seen;
  logic             ref_sat, fb_sat;
  logic [CNT_W-1:0] ref_period_new, fb_period_new, phase_new;
  logic [CNT_W-1:0] fb_period_cur, phase_cur;
  logic             eval, match;

  // Saturating increment shared by all counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // |a - b| computed one bit wider so the subtraction cannot wrap.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic signed [CNT_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  // Distance to the nearer ref edge: lagging offset or period minus it (fb leading).
  function automatic logic [CNT_W:0] phase_metric(input logic [CNT_W-1:0] ph,
                                                  input logic [CNT_W-1:0] per);
    logic signed [CNT_W+1:0] lead;
    lead = $signed({2'b00, per}) - $signed({2'b00, ph});
    if (lead < 0 || lead[CNT_W:0] >= {1'b0, ph}) return {1'b0, ph};
    return lead[CNT_W:0];
  endfunction

  assign ref_edge = ref_p1 & ~ref_p2;
  assign fb_edge  = fb_p1 & ~fb_p2;
  assign ref_sat  = (ref_cnt == CNT_MAX);
  assign fb_sat   = (fb_cnt == CNT_MAX);

  // Freshest measurements: a same-cycle fb edge is folded into the evaluation.
  assign ref_period_new = sat_inc(ref_cnt);
  assign fb_period_new  = sat_inc(fb_cnt);
  assign phase_new      = ref_edge ? '0 : sat_inc(phase_cnt);
  assign fb_period_cur  = fb_edge ? fb_period_new : fb_period;
  assign phase_cur      = fb_edge ? phase_new : phase_err;

  assign eval  = ref_edge && primed && (state != IDLE);
  assign match = fb_seen && !ref_sat && !fb_sat &&
                 (abs_diff(ref_period_new, fb_period_cur) <= TOL_V) &&
                 (phase_metric(phase_cur, ref_period_new) <= PHASE_TOL_V);

  assign locked = (state == LOCKED);

  // Stage p0/p1: two-flop synchronizers; stage p2: delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_p0 <= 1'b0;
      ref_p1 <= 1'b0;
      ref_p2 <= 1'b0;
      fb_p0  <= 1'b0;
      fb_p1  <= 1'b0;
      fb_p2  <= 1'b0;
    end else begin
      ref_p0 <= ref_in;
      ref_p1 <= ref_p0;
      ref_p2 <= ref_p1;
      fb_p0  <= fb_in;
      fb_p1  <= fb_p0;
      fb_p2  <= fb_p1;
    end
  end

  // Period, phase and window counters; held cleared while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt   <= '0;
      fb_cnt    <= '0;
      phase_cnt <= '0;
      fb_seen   <= 1'b0;
    end else if (!enable) begin
      ref_cnt   <= '0;
      fb_cnt    <= '0;
      phase_cnt <= '0;
      fb_seen   <= 1'b0;
    end else begin
      ref_cnt   <= ref_edge ? '0 : sat_inc(ref_cnt);
      fb_cnt    <= fb_edge ? '0 : sat_inc(fb_cnt);
      phase_cnt <= ref_edge ? '0 : sat_inc(phase_cnt);
      if (ref_edge)
        fb_seen <= fb_edge;
      else if (fb_edge)
        fb_seen <= 1'b1;
    end
  end

  // Measurement outputs latch on their own edge and hold while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_period <= '0;
      fb_period  <= '0;
      phase_err  <= '0;
    end else if (enable) begin
      if (ref_edge)
        ref_period <= ref_period_new;
      if (fb_edge) begin
        fb_period <= fb_period_new;
        phase_err <= phase_new;
      end
    end
  end

  // Lock FSM state register with match/miss hysteresis counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      match_cnt <= '0;
      miss_cnt  <= '0;
      primed    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      primed    <= primed_nxt;
      lock_lost <= lost_nxt;
    end
  end

  // Next-state logic: enable has priority, then reference timeout, then edge evaluation.
  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    miss_nxt   = miss_cnt;
    primed_nxt = primed;
    lost_nxt   = 1'b0;
    if (!enable) begin
      state_nxt  = IDLE;
      match_nxt  = '0;
      miss_nxt   = '0;
      primed_nxt = 1'b0;
    end else begin
      if (ref_edge) primed_nxt = 1'b1;
      case (state)
        IDLE: begin
          state_nxt  = ACQUIRE;
          match_nxt  = '0;
          miss_nxt   = '0;
          primed_nxt = 1'b0;
        end
        ACQUIRE: begin
          if (eval) begin
            if (!match) begin
              match_nxt = '0;
            end else if (match_cnt == LOCK_LAST) begin
              state_nxt = LOCKED;
              match_nxt = '0;
              miss_nxt  = '0;
            end else begin
              match_nxt = match_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (ref_sat) begin
            state_nxt = ACQUIRE;
            match_nxt = '0;
            miss_nxt  = '0;
            lost_nxt  = 1'b1;
          end else if (eval) begin
            if (match) begin
              miss_nxt = '0;
            end else if (miss_cnt == MISS_LAST) begin
              state_nxt = ACQUIRE;
              match_nxt = '0;
              miss_nxt  = '0;
              lost_nxt  = 1'b1;
            end else begin
              miss_nxt = miss_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
